// File: rtl/banco_registradores_param.sv
// Two-read/one-write register bank with a per-register LOAD-pending scoreboard.
// Latency: doutA/doutB/validA/validB one cycle after address; any_pend is combinational from state.
// Backpressure: none; the controller stalls reads itself using validA/validB/any_pend.
module banco_registradores_param #(
  parameter int DATA_W   = 64,
  parameter int ADDR_W   = 5,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] Rw,
  input  logic [DATA_W-1:0] din,
  input  logic [ADDR_W-1:0] Ra,
  input  logic [ADDR_W-1:0] Rb,
  output logic [DATA_W-1:0] doutA,
  output logic [DATA_W-1:0] doutB,
  output logic              validA,
  output logic              validB,
  input  logic              set_pend,
  input  logic [ADDR_W-1:0] Rp,
  output logic              any_pend
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  pend;
  logic [DEPTH-1:0]  pend_set;
  logic [DEPTH-1:0]  pend_nxt;
  logic              wr_ok;
  logic              set_ok;
  logic [DATA_W-1:0] rd_a;
  logic [DATA_W-1:0] rd_b;
  logic              va_nxt;
  logic              vb_nxt;

  assign wr_ok    = we && !(ZERO_REG && (Rw == '0));
  assign set_ok   = set_pend && !(ZERO_REG && (Rp == '0));
  assign any_pend = |pend;

  // Set is applied after the clear so a reissued LOAD to the same register wins.
  always_comb begin
    pend_set = pend;
    pend_nxt = pend;
    if (set_ok) begin
      pend_set[Rp] = 1'b1;
    end
    if (we) begin
      pend_nxt[Rw] = 1'b0;
    end
    if (set_ok) begin
      pend_nxt[Rp] = 1'b1;
    end
  end

  always_comb begin
    rd_a = regs[Ra];
    rd_b = regs[Rb];
    if (ZERO_REG && (Ra == '0)) begin
      rd_a = '0;
    end else if (BYPASS && we && (Ra == Rw)) begin
      rd_a = din;
    end
    if (ZERO_REG && (Rb == '0)) begin
      rd_b = '0;
    end else if (BYPASS && we && (Rb == Rw)) begin
      rd_b = din;
    end
  end

  // Without forwarding, a same-cycle write has not yet cleared the mark for the reader.
  always_comb begin
    va_nxt = BYPASS ? !pend_nxt[Ra] : !pend_set[Ra];
    vb_nxt = BYPASS ? !pend_nxt[Rb] : !pend_set[Rb];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
      pend   <= '0;
      doutA  <= '0;
      doutB  <= '0;
      validA <= 1'b1;
      validB <= 1'b1;
    end else begin
      if (wr_ok) begin
        regs[Rw] <= din;
      end
      pend   <= pend_nxt;
      doutA  <= rd_a;
      doutB  <= rd_b;
      validA <= va_nxt;
      validB <= vb_nxt;
    end
  end

endmodule

// File: tb/tb_banco_registradores_param.sv
// Bench for banco_registradores_param: default build, a no-bypass build and a 32x8 build
// driven side by side; expectations are queued per cycle and checked by a monitor.
module tb_banco_registradores_param;

  localparam logic [63:0] NEG7 = 64'hFFFF_FFFF_FFFF_FFF9;
  localparam logic [63:0] BIG  = 64'h8000_0000_0000_0001;

  typedef struct {
    logic [2:0]        en;
    logic [2:0][63:0]  a;
    logic [2:0][63:0]  b;
    logic [2:0]        va;
    logic [2:0]        vb;
    logic [2:0]        ap;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;

  logic [2:0]       we_i, sp_i;
  logic [2:0][4:0]  rw_i, ra_i, rb_i, rp_i;
  logic [2:0][63:0] din_i;

  logic [63:0] doa0, dob0, doa1, dob1;
  logic [31:0] doa2, dob2;
  logic [2:0]  va_o, vb_o, ap_o;

  logic [2:0][63:0] act_a, act_b;
  assign act_a = {{32'b0, doa2}, doa1, doa0};
  assign act_b = {{32'b0, dob2}, dob1, dob0};

  exp_t q[$];
  exp_t cur;
  exp_t mon_e;
  int   total = 0;
  int   bad   = 0;
  logic [31:0] sv [8];

  always #5 clk = ~clk;

  banco_registradores_param u_d0 (
    .clk(clk), .rst_n(rst_n), .we(we_i[0]), .Rw(rw_i[0]), .din(din_i[0]),
    .Ra(ra_i[0]), .Rb(rb_i[0]), .doutA(doa0), .doutB(dob0), .validA(va_o[0]),
    .validB(vb_o[0]), .set_pend(sp_i[0]), .Rp(rp_i[0]), .any_pend(ap_o[0])
  );

  banco_registradores_param #(.BYPASS(1'b0)) u_d1 (
    .clk(clk), .rst_n(rst_n), .we(we_i[1]), .Rw(rw_i[1]), .din(din_i[1]),
    .Ra(ra_i[1]), .Rb(rb_i[1]), .doutA(doa1), .doutB(dob1), .validA(va_o[1]),
    .validB(vb_o[1]), .set_pend(sp_i[1]), .Rp(rp_i[1]), .any_pend(ap_o[1])
  );

  banco_registradores_param #(.DATA_W(32), .ADDR_W(3)) u_d2 (
    .clk(clk), .rst_n(rst_n), .we(we_i[2]), .Rw(rw_i[2][2:0]), .din(din_i[2][31:0]),
    .Ra(ra_i[2][2:0]), .Rb(rb_i[2][2:0]), .doutA(doa2), .doutB(dob2), .validA(va_o[2]),
    .validB(vb_o[2]), .set_pend(sp_i[2]), .Rp(rp_i[2][2:0]), .any_pend(ap_o[2])
  );

  task automatic chk(input string nm, input int k, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s dut%0d t=%0t got=%h want=%h", nm, k, $time, got, exp);
    end
  endtask

  task automatic idle();
    we_i = '0; sp_i = '0; rw_i = '0; ra_i = '0; rb_i = '0; rp_i = '0; din_i = '0;
  endtask

  task automatic drv(input int k, input logic w, input logic [4:0] rw, input logic [63:0] d,
                     input logic [4:0] ra, input logic [4:0] rb, input logic s, input logic [4:0] rp);
    we_i[k] = w; rw_i[k] = rw; din_i[k] = d;
    ra_i[k] = ra; rb_i[k] = rb; sp_i[k] = s; rp_i[k] = rp;
  endtask

  task automatic ex(input int k, input logic [63:0] a, input logic [63:0] b,
                    input logic va, input logic vb, input logic ap);
    cur.en[k] = 1'b1; cur.a[k] = a; cur.b[k] = b;
    cur.va[k] = va; cur.vb[k] = vb; cur.ap[k] = ap;
  endtask

  task automatic step();
    q.push_back(cur);
    cur.en = '0;
    @(negedge clk);
    idle();
  endtask

  task automatic small_wr(input int k);
    drv(2, 1'b1, k[4:0], {32'b0, sv[k]}, 5'd0, 5'd0, 1'b0, 5'd0);
    ex(2, 64'd0, 64'd0, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic small_rd(input int ka, input int kb);
    drv(2, 1'b0, 5'd0, 64'd0, ka[4:0], kb[4:0], 1'b0, 5'd0);
    ex(2, (ka == 0) ? 64'd0 : {32'b0, sv[ka]}, (kb == 0) ? 64'd0 : {32'b0, sv[kb]},
       1'b1, 1'b1, 1'b0);
  endtask

  task automatic chk_reset_state();
    for (int k = 0; k < 3; k++) begin
      chk("rst_doutA", k, act_a[k], 64'd0);
      chk("rst_doutB", k, act_b[k], 64'd0);
      chk("rst_validA", k, {63'b0, va_o[k]}, 64'd1);
      chk("rst_validB", k, {63'b0, vb_o[k]}, 64'd1);
      chk("rst_any_pend", k, {63'b0, ap_o[k]}, 64'd0);
    end
  endtask

  // Monitor: every edge with a queued expectation is checked just after the edge.
  always @(posedge clk) begin
    if (q.size() > 0) begin
      mon_e = q.pop_front();
      #1;
      for (int k = 0; k < 3; k++) begin
        if (mon_e.en[k]) begin
          chk("doutA", k, act_a[k], mon_e.a[k]);
          chk("doutB", k, act_b[k], mon_e.b[k]);
          chk("validA", k, {63'b0, va_o[k]}, {63'b0, mon_e.va[k]});
          chk("validB", k, {63'b0, vb_o[k]}, {63'b0, mon_e.vb[k]});
          chk("any_pend", k, {63'b0, ap_o[k]}, {63'b0, mon_e.ap[k]});
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout t=%0t", $time);
    $fatal(1, "bench timeout");
  end

  initial begin
    sv[0] = 32'h1234_5678; sv[1] = 32'h8000_0000; sv[2] = 32'h7FFF_FFFF; sv[3] = 32'hFFFF_FFFF;
    sv[4] = 32'h0000_0001; sv[5] = 32'hFFFF_FFF9; sv[6] = 32'hDEAD_BEEF; sv[7] = 32'h0000_0024;
    cur.en = '0;
    rst_n = 1'b0;
    idle();
    repeat (2) @(negedge clk);
    chk_reset_state();
    rst_n = 1'b1;

    // c1
    drv(0, 1, 3, 64'd36, 1, 1, 0, 0);     ex(0, 0, 0, 1, 1, 0);
    drv(1, 1, 5, 64'd100, 5, 5, 0, 0);    ex(1, 0, 0, 1, 1, 0);
    small_wr(0); step();
    // c2
    drv(0, 0, 0, 0, 3, 1, 0, 0);          ex(0, 64'd36, 0, 1, 1, 0);
    drv(1, 1, 5, NEG7, 5, 0, 0, 0);       ex(1, 64'd100, 0, 1, 1, 0);
    small_wr(1); step();
    // c3
    drv(0, 1, 5, NEG7, 5, 3, 0, 0);       ex(0, NEG7, 64'd36, 1, 1, 0);
    drv(1, 0, 0, 0, 5, 0, 0, 0);          ex(1, NEG7, 0, 1, 1, 0);
    small_wr(2); step();
    // c4
    drv(0, 1, 0, 64'd45, 0, 5, 1, 0);     ex(0, 0, NEG7, 1, 1, 0);
    drv(1, 0, 0, 0, 5, 0, 1, 5);          ex(1, NEG7, 0, 0, 1, 1);
    small_wr(3); step();
    // c5
    drv(0, 0, 0, 0, 0, 0, 0, 0);          ex(0, 0, 0, 1, 1, 0);
    drv(1, 1, 5, 64'd9, 5, 5, 0, 0);      ex(1, NEG7, NEG7, 0, 0, 0);
    small_wr(4); step();
    // c6
    drv(0, 0, 0, 0, 2, 3, 1, 2);          ex(0, 0, 64'd36, 0, 1, 1);
    drv(1, 0, 0, 0, 5, 5, 0, 0);          ex(1, 64'd9, 64'd9, 1, 1, 0);
    small_wr(5); step();
    // c7
    drv(0, 0, 0, 0, 2, 0, 0, 0);          ex(0, 0, 0, 0, 1, 1);
    drv(1, 1, 0, 64'd45, 0, 0, 1, 0);     ex(1, 0, 0, 1, 1, 0);
    small_wr(6); step();
    // c8
    drv(0, 1, 2, 64'd11, 2, 2, 0, 0);     ex(0, 64'd11, 64'd11, 1, 1, 0);
    drv(1, 0, 0, 0, 0, 0, 0, 0);          ex(1, 0, 0, 1, 1, 0);
    small_wr(7); step();
    // c9: LOAD reissued to the register being written stays pending
    drv(0, 1, 2, 64'd22, 2, 5, 1, 2);     ex(0, 64'd22, NEG7, 0, 1, 1);
    small_rd(0, 1); step();
    // c10
    drv(0, 0, 0, 0, 2, 0, 0, 0);          ex(0, 64'd22, 0, 0, 1, 1);
    small_rd(2, 3); step();
    // c11
    drv(0, 1, 2, 64'd33, 7, 2, 1, 7);     ex(0, 0, 64'd33, 0, 1, 1);
    small_rd(4, 5); step();
    // c12
    drv(0, 1, 7, BIG, 7, 7, 0, 0);        ex(0, BIG, BIG, 1, 1, 0);
    small_rd(6, 7); step();
    // c13
    drv(0, 0, 0, 0, 7, 3, 1, 4);          ex(0, BIG, 64'd36, 1, 1, 1);
    small_rd(3, 2); step();

    // Mid-cycle asynchronous reset with a pending LOAD outstanding.
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_state();
    @(negedge clk);
    rst_n = 1'b1;

    // c14: contents cleared by reset
    drv(0, 0, 0, 0, 3, 7, 0, 0);          ex(0, 0, 0, 1, 1, 0);
    drv(1, 0, 0, 0, 5, 5, 0, 0);          ex(1, 0, 0, 1, 1, 0);
    small_rd(1, 6);
    ex(2, 0, 0, 1, 1, 0);
    step();

    repeat (2) @(negedge clk);
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL queue_drain left=%0d want=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/banco_registradores_param.md
Name: banco_registradores_param

Overview:
- Parametrised successor to the datapath's two-read/one-write register bank, for the next-generation dataflow core.
- Configurable data width and depth.
- Optional hardwired-zero register 0 and write-to-read bypass.
- Per-register pending scoreboard, so the controller can stall reads of registers whose LOAD result has not returned from memoria.
- Sits between the instruction decode and the adder/Mux1/Mux2 datapath.

Parameters:
DATA_W, 64, width of each register and of din/doutA/doutB
ADDR_W, 5, address width; depth = 2**ADDR_W registers
ZERO_REG, 1, 1: register 0 always reads 0, writes to it discarded, never pending
BYPASS, 1, 1: same-cycle write to a register being read is forwarded to the read output

Ports:
clk  input  1  system clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
we  input  1  write enable for port W
Rw  input  ADDR_W  write address
din  input  DATA_W  signed write data
Ra  input  ADDR_W  read address A
Rb  input  ADDR_W  read address B
doutA  output  DATA_W  registered signed read data A
doutB  output  DATA_W  registered signed read data B
validA  output  1  registered: register Ra was not pending at the sampling edge
validB  output  1  registered: register Rb was not pending at the sampling edge
set_pend  input  1  mark register Rp pending (LOAD issued)
Rp  input  ADDR_W  register to mark pending
any_pend  output  1  combinational OR of all pending bits

Behaviour:
- Reset (rst_n low, asynchronous, dominates everything):
  - all registers = 0; all pending bits = 0
  - doutA = doutB = 0; validA = validB = 1
  - state is held while rst_n stays low
  - first edge after release behaves as a normal cycle
- Read latency is 1 cycle. At each rising edge:
  - doutA <= value of register Ra; doutB <= value of register Rb
  - reads occur every cycle regardless of we
- Write: if we, register Rw <= din at the edge.
  - If ZERO_REG=1 and Rw=0, the write is discarded.
- Bypass (read address equals Rw in the same cycle as we):
  - BYPASS=1: doutX <= din
  - BYPASS=0: doutX <= old register contents
  - If ZERO_REG=1 and the address is 0, doutX <= 0 regardless of BYPASS.
- Pending scoreboard:
  - set_pend sets pending[Rp]; we clears pending[Rw].
  - set_pend and we on the same address in the same cycle: set wins (a new LOAD reissued to the same destination).
  - ZERO_REG=1: pending[0] is never set.
- Valid flags:
  - validX <= NOT pending[RX] evaluated after this edge's updates.
  - So a same-cycle we clearing RX yields valid=1 when BYPASS=1.
  - When BYPASS=0, validX uses pending before the clear, so valid=0.
- Widths and index range:
  - Addresses are exactly ADDR_W bits, so there is no out-of-range index.
  - din is stored unmodified, with no sign extension or truncation.
- Mid-operation reset: pending LOAD marks are lost. The controller must reissue.
- No X propagation: every register is initialised by reset, with no reliance on initial blocks.

Test Plan:
1. Reset check: assert rst_n=0 mid-cycle after writes -> doutA=doutB=0, validA=validB=1, any_pend=0 immediately, without waiting for a clock edge.
2. Basic write/read: we=1, Rw=3, din=36; next cycle Ra=3, Rb=1 -> one edge later doutA=36, doutB=0.
3. Bypass:
   - BYPASS=1: we=1, Rw=5, din=-7 with Ra=5 in the same cycle -> doutA=-7 after the edge.
   - Repeat with BYPASS=0 -> doutA equals the previous contents of register 5.
4. Zero register: ZERO_REG=1, we=1, Rw=0, din=45, set_pend with Rp=0 -> Ra=0 reads 0, validA=1, any_pend=0.
5. Scoreboard:
   - set_pend with Rp=2 -> any_pend=1; Ra=2 -> validA=0.
   - we with Rw=2, din=11 -> validA=1, doutA=11, any_pend=0.
   - set_pend and we on register 2 in the same cycle -> register stays pending.
6. Parameter sweep: DATA_W=32, ADDR_W=3 -> write all 8 registers with distinct signed values including 32'h8000_0000, read back via both ports -> all match, with no sign or width corruption.
